// File: rtl/quadrature_encoder_pkg.sv
// Shared definitions for the quadrature encoder interface block.
// Holds the register map, CTRL/STATUS bit positions, the default core
// identifier and the x4 step decoder used by the top level.
package quadrature_encoder_pkg;

  localparam logic [2:0] ADDR_ID       = 3'd0;
  localparam logic [2:0] ADDR_POSITION = 3'd1;
  localparam logic [2:0] ADDR_CTRL     = 3'd2;
  localparam logic [2:0] ADDR_STATUS   = 3'd3;
  localparam logic [2:0] ADDR_PRESET   = 3'd4;
  localparam logic [2:0] ADDR_LATCH    = 3'd5;

  localparam int CTRL_EN      = 0;
  localparam int CTRL_ZCLR    = 1;
  localparam int CTRL_DIR_INV = 2;

  localparam int STATUS_DIR = 0;
  localparam int STATUS_IDX = 1;
  localparam int STATUS_ERR = 2;

  localparam logic [31:0] DEFAULT_CORE_ID = 32'hEA680004;

  typedef enum logic [1:0] {
    STEP_NONE = 2'd0,
    STEP_FWD  = 2'd1,
    STEP_REV  = 2'd2,
    STEP_ERR  = 2'd3
  } step_e;

  // Position of an {A,B} pair along the forward cycle 00->01->11->10.
  function automatic logic [1:0] gray_phase(input logic [1:0] ab);
    logic [1:0] ph;
    case (ab)
      2'b00:   ph = 2'd0;
      2'b01:   ph = 2'd1;
      2'b11:   ph = 2'd2;
      default: ph = 2'd3;
    endcase
    return ph;
  endfunction

  // Phase difference modulo 4: +1 forward, -1 reverse, 2 means both bits flipped.
  function automatic step_e decode_step(input logic [1:0] prev_ab,
                                        input logic [1:0] cur_ab);
    logic [1:0] d;
    step_e      s;
    d = gray_phase(cur_ab) - gray_phase(prev_ab);
    case (d)
      2'd1:    s = STEP_FWD;
      2'd3:    s = STEP_REV;
      2'd2:    s = STEP_ERR;
      default: s = STEP_NONE;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/encoder_input_filter.sv
// One-bit input conditioner: 2-FF synchroniser followed by a run-length
// filter. The output only moves to a new level after FILTER_LEN consecutive
// synchronised samples that all differ from the current output.
// Ports:
//   clk  - clock
//   rst  - synchronous active-high reset
//   din  - asynchronous input
//   dout - synchronised, filtered level (resets to 0)
module encoder_input_filter #(
  parameter int FILTER_LEN = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic dout
);

  logic       sync_p0;
  logic       sync_p1;
  logic [3:0] run_cnt;
  logic [3:0] run_inc;

  assign run_inc = run_cnt + 4'd1;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_p0 <= 1'b0;
      sync_p1 <= 1'b0;
      dout    <= 1'b0;
      run_cnt <= 4'd0;
    end else begin
      // synchroniser stages
      sync_p0 <= din;
      sync_p1 <= sync_p0;
      // filter stage: a sample equal to the output breaks the run
      if (sync_p1 != dout) begin
        if (run_inc == 4'(FILTER_LEN)) begin
          dout    <= sync_p1;
          run_cnt <= 4'd0;
        end else begin
          run_cnt <= run_inc;
        end
      end else begin
        run_cnt <= 4'd0;
      end
    end
  end

endmodule

// File: rtl/quadrature_encoder.sv
// Quadrature encoder interface with Avalon-MM control slave.
// A/B/Z are synchronised and filtered, {A,B} is decoded x4 into a signed
// position counter, and a rising Z edge latches (and optionally clears) it.
// Ports:
//   csi_MCLK_clk          - clock
//   rsi_MRST_reset        - synchronous active-high reset
//   avs_ctrl_*            - register access (address, read, write, data);
//                           byteenable ignored, waitrequest tied 0
//   A, B, Z               - asynchronous encoder inputs
module quadrature_encoder
  import quadrature_encoder_pkg::*;
#(
  parameter int          POS_WIDTH  = 32,
  parameter int          FILTER_LEN = 3,
  parameter logic [31:0] CORE_ID    = DEFAULT_CORE_ID
) (
  input  logic        csi_MCLK_clk,
  input  logic        rsi_MRST_reset,
  input  logic [31:0] avs_ctrl_writedata,
  output logic [31:0] avs_ctrl_readdata,
  input  logic [3:0]  avs_ctrl_byteenable,
  input  logic [2:0]  avs_ctrl_address,
  input  logic        avs_ctrl_write,
  input  logic        avs_ctrl_read,
  output logic        avs_ctrl_waitrequest,
  input  logic        A,
  input  logic        B,
  input  logic        Z
);

  logic a_filt, b_filt, z_filt;

  encoder_input_filter #(.FILTER_LEN(FILTER_LEN)) u_filt_a (
    .clk(csi_MCLK_clk), .rst(rsi_MRST_reset), .din(A), .dout(a_filt));
  encoder_input_filter #(.FILTER_LEN(FILTER_LEN)) u_filt_b (
    .clk(csi_MCLK_clk), .rst(rsi_MRST_reset), .din(B), .dout(b_filt));
  encoder_input_filter #(.FILTER_LEN(FILTER_LEN)) u_filt_z (
    .clk(csi_MCLK_clk), .rst(rsi_MRST_reset), .din(Z), .dout(z_filt));

  logic signed [POS_WIDTH-1:0] position;
  logic signed [POS_WIDTH-1:0] latch_pos;
  logic signed [POS_WIDTH-1:0] pos_next;
  logic [2:0]                  ctrl;
  logic                        st_dir, st_idx, st_err;
  logic [1:0]                  ab_p1;
  logic                        z_p1;

  step_e step;
  logic  en, zclr, dir_inv;
  logic  moving, count_up, z_rise;
  logic  wr_ctrl, wr_status, wr_preset;
  logic  unused_ok;

  assign avs_ctrl_waitrequest = 1'b0;
  assign unused_ok = ^{avs_ctrl_byteenable, avs_ctrl_writedata};

  assign en      = ctrl[CTRL_EN];
  assign zclr    = ctrl[CTRL_ZCLR];
  assign dir_inv = ctrl[CTRL_DIR_INV];

  assign wr_ctrl   = avs_ctrl_write && (avs_ctrl_address == ADDR_CTRL);
  assign wr_status = avs_ctrl_write && (avs_ctrl_address == ADDR_STATUS);
  assign wr_preset = avs_ctrl_write && (avs_ctrl_address == ADDR_PRESET);

  // Compare the filtered pair against last cycle's copy so the counter
  // moves exactly one cycle after the filtered change.
  assign step     = decode_step(ab_p1, {a_filt, b_filt});
  assign moving   = en && ((step == STEP_FWD) || (step == STEP_REV));
  assign count_up = (step == STEP_FWD) ^ dir_inv;
  assign z_rise   = en && z_filt && !z_p1;

  // PRESET beats a Z clear, which beats the count step.
  always_comb begin
    pos_next = position;
    if (wr_preset)
      pos_next = avs_ctrl_writedata[POS_WIDTH-1:0];
    else if (z_rise && zclr)
      pos_next = '0;
    else if (moving)
      pos_next = count_up ? position + POS_WIDTH'(1) : position - POS_WIDTH'(1);
  end

  always_ff @(posedge csi_MCLK_clk) begin
    if (rsi_MRST_reset) begin
      ab_p1             <= 2'b00;
      z_p1              <= 1'b0;
      position          <= '0;
      latch_pos         <= '0;
      ctrl              <= 3'd0;
      st_dir            <= 1'b0;
      st_idx            <= 1'b0;
      st_err            <= 1'b0;
      avs_ctrl_readdata <= 32'd0;
    end else begin
      // decode/count stage
      ab_p1    <= {a_filt, b_filt};
      z_p1     <= z_filt;
      position <= pos_next;
      if (z_rise)
        latch_pos <= position;
      if (moving)
        st_dir <= count_up;
      if (wr_ctrl)
        ctrl <= avs_ctrl_writedata[2:0];
      // a set event in the same cycle as a W1C clear wins
      st_idx <= (st_idx && !(wr_status && avs_ctrl_writedata[STATUS_IDX])) || z_rise;
      st_err <= (st_err && !(wr_status && avs_ctrl_writedata[STATUS_ERR])) ||
                (en && (step == STEP_ERR));
      if (avs_ctrl_read) begin
        case (avs_ctrl_address)
          ADDR_ID:       avs_ctrl_readdata <= CORE_ID;
          ADDR_POSITION: avs_ctrl_readdata <= 32'(position);
          ADDR_CTRL:     avs_ctrl_readdata <= {29'd0, ctrl};
          ADDR_STATUS:   avs_ctrl_readdata <= {29'd0, st_err, st_idx, st_dir};
          ADDR_LATCH:    avs_ctrl_readdata <= 32'(latch_pos);
          default:       avs_ctrl_readdata <= 32'd0;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_quadrature_encoder.sv
module tb_quadrature_encoder;

  localparam logic [31:0] CORE_ID = 32'hEA680004;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic [3:0]  be;
  logic [2:0]  addr;
  logic        wr, rd;
  logic        waitreq;
  logic        A, B, Z;

  always #5 clk = ~clk;

  quadrature_encoder #(.POS_WIDTH(32), .FILTER_LEN(3), .CORE_ID(CORE_ID)) dut (
    .csi_MCLK_clk(clk), .rsi_MRST_reset(rst),
    .avs_ctrl_writedata(wdata), .avs_ctrl_readdata(rdata),
    .avs_ctrl_byteenable(be), .avs_ctrl_address(addr),
    .avs_ctrl_write(wr), .avs_ctrl_read(rd), .avs_ctrl_waitrequest(waitreq),
    .A(A), .B(B), .Z(Z));

  // Reference model state
  logic [31:0] m_pos, m_latch;
  logic [2:0]  m_ctrl;
  logic        m_dir, m_idx, m_err;
  logic [1:0]  m_ab;

  logic [31:0] exp_q[$];
  string       name_q[$];
  int          n_vec = 0;
  int          n_fail = 0;

  function automatic logic [31:0] model_reg(input logic [2:0] a);
    case (a)
      3'd0:    return CORE_ID;
      3'd1:    return m_pos;
      3'd2:    return {29'd0, m_ctrl};
      3'd3:    return {29'd0, m_err, m_idx, m_dir};
      3'd5:    return m_latch;
      default: return 32'd0;
    endcase
  endfunction

  function automatic int cycle_index(input logic [1:0] ab);
    logic [1:0] seq [4] = '{2'b00, 2'b01, 2'b11, 2'b10};
    for (int i = 0; i < 4; i++) if (seq[i] == ab) return i;
    return 0;
  endfunction

  task automatic model_reset();
    m_pos = 0; m_latch = 0; m_ctrl = 0; m_dir = 0; m_idx = 0; m_err = 0;
  endtask

  // Monitor: every accepted read produces readdata one cycle later.
  always @(posedge clk) begin
    if (rd && !rst) begin
      logic [31:0] e;
      string nm;
      @(negedge clk);
      n_vec++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_read: got 0x%08h, no expected value queued", rdata);
      end else begin
        e  = exp_q.pop_front();
        nm = name_q.pop_front();
        if (rdata !== e) begin
          n_fail++;
          $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, rdata, e);
        end
      end
    end
  end

  task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
    @(negedge clk);
    addr = a; wdata = d; wr = 1'b1;
    @(negedge clk);
    wr = 1'b0;
  endtask

  task automatic reg_write(input logic [2:0] a, input logic [31:0] d);
    bus_write(a, d);
    case (a)
      3'd2: m_ctrl = d[2:0];
      3'd3: begin
        if (d[1]) m_idx = 1'b0;
        if (d[2]) m_err = 1'b0;
      end
      3'd4: m_pos = d;
      default: ;
    endcase
  endtask

  task automatic bus_read(input logic [2:0] a, input string nm);
    @(negedge clk);
    addr = a; rd = 1'b1;
    exp_q.push_back(model_reg(a));
    name_q.push_back(nm);
    @(negedge clk);
    rd = 1'b0;
  endtask

  task automatic settle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Drive a new {A,B} level and hold it; the model applies x4 rules directly.
  task automatic step_ab(input logic [1:0] ab, input int hold);
    int diff;
    logic fwd;
    @(negedge clk);
    A = ab[1]; B = ab[0];
    diff = (cycle_index(ab) - cycle_index(m_ab) + 4) % 4;
    if (m_ctrl[0]) begin
      if (diff == 1 || diff == 3) begin
        fwd = (diff == 1) ^ m_ctrl[2];
        m_pos = fwd ? m_pos + 32'd1 : m_pos - 32'd1;
        m_dir = fwd;
      end else if (diff == 2) begin
        m_err = 1'b1;
      end
    end
    m_ab = ab;
    repeat (hold - 1) @(negedge clk);
  endtask

  task automatic pulse_z(input int hold);
    @(negedge clk);
    Z = 1'b1;
    if (m_ctrl[0]) begin
      m_latch = m_pos;
      m_idx = 1'b1;
      if (m_ctrl[1]) m_pos = 0;
    end
    settle(hold);
    Z = 1'b0;
    settle(hold);
  endtask

  initial begin
    rst = 1'b1; wdata = 0; be = 4'hF; addr = 0; wr = 0; rd = 0;
    A = 0; B = 0; Z = 0; m_ab = 2'b00;
    model_reset();
    settle(3);
    rst = 1'b0;
    settle(1);

    n_vec++;
    if (rdata !== 32'd0) begin
      n_fail++;
      $display("FAIL readdata_reset: got 0x%08h, expected 0x00000000", rdata);
    end
    for (int i = 0; i < 8; i++) bus_read(3'(i), $sformatf("reset_reg%0d", i));

    // Four forward steps
    reg_write(3'd2, 32'h1);
    step_ab(2'b01, 5); step_ab(2'b11, 5); step_ab(2'b10, 5); step_ab(2'b00, 5);
    settle(4);
    bus_read(3'd1, "fwd4_position");
    bus_read(3'd3, "fwd4_status");

    // Wrap forward from all ones
    reg_write(3'd4, 32'hFFFF_FFFF);
    step_ab(2'b01, 5);
    settle(4);
    bus_read(3'd1, "wrap_position");

    // Two reverse steps from 0
    reg_write(3'd4, 32'h0);
    step_ab(2'b00, 5); step_ab(2'b10, 5);
    settle(4);
    bus_read(3'd1, "rev2_position");
    bus_read(3'd3, "rev2_status");

    // One-cycle glitch on A is rejected
    @(negedge clk); A = ~A;
    @(negedge clk); A = m_ab[1];
    settle(8);
    bus_read(3'd1, "glitch_position");
    bus_read(3'd3, "glitch_status");

    // Both bits change: no count, err set
    step_ab(2'b01, 5);
    settle(4);
    bus_read(3'd1, "dbl_position");
    bus_read(3'd3, "dbl_status");
    reg_write(3'd3, 32'h4);
    bus_read(3'd3, "err_w1c_status");

    // Direction inversion
    reg_write(3'd2, 32'h5);
    step_ab(2'b11, 5); step_ab(2'b10, 5);
    settle(4);
    bus_read(3'd1, "inv_position");
    bus_read(3'd3, "inv_status");

    // Z latch and clear
    reg_write(3'd4, 32'd37);
    reg_write(3'd2, 32'h3);
    pulse_z(5);
    settle(4);
    bus_read(3'd5, "zclr_latch");
    bus_read(3'd1, "zclr_position");
    bus_read(3'd3, "zclr_status");
    reg_write(3'd3, 32'h2);
    bus_read(3'd3, "idx_w1c_status");

    // PRESET write in the same cycle as the filtered Z rise
    reg_write(3'd4, 32'd55);
    @(negedge clk); Z = 1'b1;
    settle(4);
    bus_write(3'd4, 32'd100);
    m_latch = m_pos; m_idx = 1'b1; m_pos = 32'd100;
    settle(4);
    Z = 1'b0;
    settle(8);
    bus_read(3'd1, "preset_vs_z_position");
    bus_read(3'd5, "preset_vs_z_latch");

    // Randomised operations
    for (int i = 0; i < 80; i++) begin
      int op;
      op = $urandom_range(0, 5);
      case (op)
        0, 1: step_ab(2'($urandom_range(0, 3)), 8);
        2:    pulse_z(8);
        3:    reg_write(3'd2, 32'($urandom_range(0, 7)) | 32'h1);
        4:    reg_write(3'd4, $urandom);
        default: reg_write(3'd3, 32'($urandom_range(0, 7)));
      endcase
      settle(3);
      bus_read(3'($urandom_range(0, 7)), $sformatf("rand%0d_op%0d", i, op));
    end

    // Reset in the middle of a filter run / count
    reg_write(3'd2, 32'h1);
    reg_write(3'd4, 32'd9);
    step_ab(m_ab ^ 2'b10, 2);
    rst = 1'b1;
    model_reset();
    settle(2);
    rst = 1'b0;
    settle(10);
    for (int i = 0; i < 8; i++) bus_read(3'(i), $sformatf("midreset_reg%0d", i));

    settle(4);
    n_vec++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL pending_reads: got %0d outstanding, expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
